// File: rtl/lsu_stage.sv
// Load/store stage: hits and ALU results write back one cycle after acceptance; misses refill a whole line first.
// Stores write through. Misses and aligned stores hold stall high until the final mem_ack.
module lsu_stage #(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [ADDR_W-1:0]             in_addr,
  input  logic [4:0]                    in_rd,
  input  logic                          in_wb_en,
  input  logic [2:0]                    in_load_type,
  input  logic [1:0]                    in_store_type,
  input  logic [XLEN-1:0]               in_store_data,
  input  logic                          cache_hit,
  input  logic [XLEN-1:0]               cache_rd_data,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [XLEN-1:0]               mem_wdata,
  output logic [XLEN/8-1:0]             mem_wstrb,
  input  logic                          mem_ack,
  input  logic [XLEN-1:0]               mem_rdata,
  output logic                          refill_we,
  output logic [$clog2(LINE_WORDS)-1:0] refill_idx,
  output logic [XLEN-1:0]               refill_data,
  output logic                          cache_wr_en,
  output logic                          stall,
  output logic                          misalign,
  output logic                          wb_valid,
  output logic                          wb_en,
  output logic [4:0]                    wb_rd,
  output logic [XLEN-1:0]               wb_data,
  output logic                          fwd_en,
  output logic [4:0]                    fwd_rd,
  output logic [XLEN-1:0]               fwd_data
);

  localparam int LANES = XLEN / 8;
  localparam int OFF   = $clog2(LANES);
  localparam int IW    = $clog2(LINE_WORDS);

  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << (OFF + IW);

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LH  = 3'd2;
  localparam logic [2:0] LT_LW  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;
  localparam logic [2:0] LT_LHU = 3'd5;

  localparam logic [1:0] ST_SB = 2'd1;
  localparam logic [1:0] ST_SH = 2'd2;
  localparam logic [1:0] ST_SW = 2'd3;

  typedef enum logic [1:0] {IDLE, REFILL, STORE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        load_type;
    logic [1:0]        store_type;
    logic [4:0]        rd;
    logic              wb_en;
    logic [XLEN-1:0]   sdata;
    logic              hit;
  } op_t;

  state_t          state;
  logic [IW-1:0]   beat;
  op_t             op;
  op_t             op_in;
  logic [XLEN-1:0] cap_data;

  logic            is_load;
  logic            is_store;
  logic            is_half;
  logic            is_word;
  logic            bad_align;
  logic            accept;
  logic            last_beat;
  logic [OFF-1:0]  in_off;
  logic [OFF-1:0]  op_off;
  logic [IW-1:0]   op_widx;
  logic [LANES-1:0] strb_base;

  // Shift the addressed lane down to bit 0, then extend per load type.
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] word,
                                              input logic [OFF-1:0]  off,
                                              input logic [2:0]      lt);
    logic [XLEN-1:0] s;
    logic [XLEN-1:0] r;
    s = word >> {off, 3'b000};
    case (lt)
      LT_LB:   r = XLEN'($signed(s[7:0]));
      LT_LH:   r = XLEN'($signed(s[15:0]));
      LT_LW:   r = XLEN'($signed(s[31:0]));
      LT_LBU:  r = XLEN'(s[7:0]);
      LT_LHU:  r = XLEN'(s[15:0]);
      default: r = s;
    endcase
    return r;
  endfunction

  always_comb begin
    in_off    = in_addr[OFF-1:0];
    is_load   = (in_load_type >= LT_LB) && (in_load_type <= LT_LHU);
    // Any nonzero load type, including the reserved 6/7, suppresses the store.
    is_store  = (in_load_type == 3'd0) && (in_store_type != 2'd0);
    is_half   = (in_load_type == LT_LH) || (in_load_type == LT_LHU) ||
                (is_store && (in_store_type == ST_SH));
    is_word   = (in_load_type == LT_LW) || (is_store && (in_store_type == ST_SW));
    bad_align = (is_half && in_addr[0]) || (is_word && (in_addr[1:0] != 2'b00));
    accept    = (state == IDLE) && in_valid;

    op_in.addr       = in_addr;
    op_in.load_type  = in_load_type;
    op_in.store_type = in_store_type;
    op_in.rd         = in_rd;
    op_in.wb_en      = in_wb_en;
    op_in.sdata      = in_store_data;
    op_in.hit        = cache_hit;
  end

  always_comb begin
    op_off    = op.addr[OFF-1:0];
    op_widx   = op.addr[OFF+IW-1:OFF];
    last_beat = (beat == IW'(LINE_WORDS - 1));

    strb_base = '0;
    case (op.store_type)
      ST_SB:   strb_base = LANES'(4'h1);
      ST_SH:   strb_base = LANES'(4'h3);
      ST_SW:   strb_base = LANES'(4'hF);
      default: strb_base = '0;
    endcase

    // Request fields come straight from the held op, so they cannot move before the ack.
    mem_req   = (state != IDLE);
    mem_we    = (state == STORE);
    mem_addr  = (state == REFILL) ? ((op.addr & LINE_MASK) | (ADDR_W'(beat) << OFF)) : op.addr;
    mem_wdata = op.sdata << {op_off, 3'b000};
    mem_wstrb = strb_base << op_off;

    refill_we   = (state == REFILL) && mem_ack;
    refill_idx  = beat;
    refill_data = refill_we ? mem_rdata : '0;
    cache_wr_en = (state == STORE) && mem_ack && op.hit;

    stall = 1'b0;
    case (state)
      IDLE:    stall = in_valid && !bad_align && (is_store || (is_load && !cache_hit));
      REFILL:  stall = !(mem_ack && last_beat);
      STORE:   stall = !mem_ack;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      op       <= '0;
      cap_data <= '0;
      misalign <= 1'b0;
      wb_valid <= 1'b0;
      wb_en    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      misalign <= 1'b0;
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op <= op_in;
            if (bad_align) begin
              misalign <= 1'b1;
              wb_valid <= 1'b1;
              wb_en    <= 1'b0;
              wb_rd    <= in_rd;
              wb_data  <= '0;
            end else if (is_store) begin
              state <= STORE;
            end else if (is_load && !cache_hit) begin
              state <= REFILL;
              beat  <= '0;
            end else begin
              wb_valid <= 1'b1;
              wb_en    <= in_wb_en;
              wb_rd    <= in_rd;
              wb_data  <= is_load ? extract(cache_rd_data, in_off, in_load_type) : XLEN'(in_addr);
            end
          end
        end
        REFILL: begin
          if (mem_ack) begin
            if (beat == op_widx) cap_data <= mem_rdata;
            if (last_beat) begin
              state    <= IDLE;
              beat     <= '0;
              wb_valid <= 1'b1;
              wb_en    <= op.wb_en;
              wb_rd    <= op.rd;
              // The requested word may arrive on this very beat.
              wb_data  <= extract((beat == op_widx) ? mem_rdata : cap_data, op_off, op.load_type);
            end else begin
              beat <= beat + IW'(1);
            end
          end
        end
        STORE: begin
          if (mem_ack) begin
            state    <= IDLE;
            wb_valid <= 1'b1;
            wb_en    <= 1'b0;
            wb_rd    <= op.rd;
            wb_data  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fwd_en   = wb_valid & wb_en;
  assign fwd_rd   = wb_rd;
  assign fwd_data = wb_data;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage (XLEN=32, ADDR_W=32, LINE_WORDS=4).
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_addr;
  logic [4:0]  in_rd;
  logic        in_wb_en;
  logic [2:0]  in_load_type;
  logic [1:0]  in_store_type;
  logic [31:0] in_store_data;
  logic        cache_hit;
  logic [31:0] cache_rd_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        refill_we;
  logic [1:0]  refill_idx;
  logic [31:0] refill_data;
  logic        cache_wr_en;
  logic        stall;
  logic        misalign;
  logic        wb_valid;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fwd_en;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_stage #(.XLEN(32), .ADDR_W(32), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_addr(in_addr), .in_rd(in_rd), .in_wb_en(in_wb_en),
    .in_load_type(in_load_type), .in_store_type(in_store_type), .in_store_data(in_store_data),
    .cache_hit(cache_hit), .cache_rd_data(cache_rd_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .refill_we(refill_we), .refill_idx(refill_idx), .refill_data(refill_data),
    .cache_wr_en(cache_wr_en), .stall(stall), .misalign(misalign),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic present(input logic [2:0] lt, input logic [1:0] st, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] rd, input logic hit,
                         input logic [31:0] crd);
    in_valid      = 1'b1;
    in_load_type  = lt;
    in_store_type = st;
    in_addr       = addr;
    in_store_data = sdata;
    in_rd         = rd;
    in_wb_en      = 1'b1;
    cache_hit     = hit;
    cache_rd_data = crd;
  endtask

  task automatic idle_in();
    in_valid      = 1'b0;
    in_load_type  = 3'd0;
    in_store_type = 2'd0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    idle_in();
    in_addr = '0; in_rd = '0; in_wb_en = 1'b0; in_store_data = '0;
    cache_hit = 1'b0; cache_rd_data = '0;
    tick(); tick(); settle();

    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_refill_we", refill_we, 0);
    chk("rst_cache_wr_en", cache_wr_en, 0);
    chk("rst_fwd_en", fwd_en, 0);
    rst = 1'b0;
    tick();

    // LB hit with sign extension from the top lane
    present(3'd1, 2'd0, 32'h0000_1003, 32'h0, 5'd5, 1'b1, 32'h80FF_FFFF);
    settle(); chk("lb_stall", stall, 0);
    tick(); idle_in(); settle();
    chk("lb_wb_valid", wb_valid, 1);
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_wb_rd", wb_rd, 5);
    chk("lb_fwd_en", fwd_en, 1);
    chk("lb_fwd_data", fwd_data, 32'hFFFF_FF80);
    chk("lb_mem_req", mem_req, 0);
    chk("lb_stall_after", stall, 0);
    tick(); settle(); chk("lb_wb_pulse", wb_valid, 0);

    // LHU then LH back-to-back on the upper half
    present(3'd5, 2'd0, 32'h0000_1002, 32'h0, 5'd6, 1'b1, 32'h8001_7FFF);
    tick();
    present(3'd2, 2'd0, 32'h0000_1002, 32'h0, 5'd7, 1'b1, 32'h8001_7FFF);
    settle(); chk("lhu_wb_data", wb_data, 32'h0000_8001);
    tick(); idle_in(); settle();
    chk("lh_wb_data", wb_data, 32'hFFFF_8001);
    chk("lh_wb_rd", wb_rd, 7);
    tick();

    // Non-memory op, then reserved load type 6 with a store type that must be ignored
    present(3'd0, 2'd0, 32'h1234_5678, 32'h0, 5'd8, 1'b0, 32'h0);
    tick();
    present(3'd6, 2'd3, 32'h0000_0055, 32'hFFFF_FFFF, 5'd9, 1'b0, 32'h0);
    settle();
    chk("alu_wb_data", wb_data, 32'h1234_5678);
    chk("lt6_stall", stall, 0);
    tick(); idle_in(); settle();
    chk("lt6_wb_valid", wb_valid, 1);
    chk("lt6_wb_data", wb_data, 32'h0000_0055);
    chk("lt6_mem_req", mem_req, 0);
    tick();

    // LW miss: four refill beats, requested word is beat 2
    present(3'd3, 2'd0, 32'h0000_2008, 32'h0, 5'd10, 1'b0, 32'hBAD0_BAD0);
    settle();
    chk("miss_stall_idle", stall, 1);
    chk("miss_req_idle", mem_req, 0);
    tick(); idle_in();
    for (int k = 0; k < 4; k++) begin
      mem_ack = 1'b1;
      mem_rdata = 32'hC0DE_0000 + k * 32'h1111;
      settle();
      chk($sformatf("refill_req_%0d", k), mem_req, 1);
      chk($sformatf("refill_we_n_%0d", k), mem_we, 0);
      chk($sformatf("refill_addr_%0d", k), mem_addr, 32'h0000_2000 + k * 4);
      chk($sformatf("refill_we_%0d", k), refill_we, 1);
      chk($sformatf("refill_idx_%0d", k), refill_idx, k);
      chk($sformatf("refill_data_%0d", k), refill_data, 32'hC0DE_0000 + k * 32'h1111);
      chk($sformatf("refill_stall_%0d", k), stall, (k == 3) ? 0 : 1);
      chk($sformatf("refill_wbv_%0d", k), wb_valid, 0);
      tick();
    end
    mem_ack = 1'b0; settle();
    chk("miss_wb_valid", wb_valid, 1);
    chk("miss_wb_data", wb_data, 32'hC0DE_2222);
    chk("miss_wb_rd", wb_rd, 10);
    chk("miss_fwd_en", fwd_en, 1);
    chk("miss_mem_req", mem_req, 0);
    chk("miss_refill_we", refill_we, 0);
    tick();

    // SH hit with the ack held off for three cycles
    present(3'd0, 2'd2, 32'h0000_3002, 32'h0000_ABCD, 5'd3, 1'b1, 32'h0);
    settle(); chk("sh_stall_idle", stall, 1);
    tick(); idle_in();
    for (int d = 0; d < 3; d++) begin
      settle();
      chk($sformatf("sh_req_%0d", d), mem_req, 1);
      chk($sformatf("sh_we_%0d", d), mem_we, 1);
      chk($sformatf("sh_addr_%0d", d), mem_addr, 32'h0000_3002);
      chk($sformatf("sh_wdata_%0d", d), mem_wdata, 32'hABCD_0000);
      chk($sformatf("sh_wstrb_%0d", d), mem_wstrb, 4'hC);
      chk($sformatf("sh_stall_%0d", d), stall, 1);
      chk($sformatf("sh_cwe_%0d", d), cache_wr_en, 0);
      tick();
    end
    mem_ack = 1'b1; settle();
    chk("sh_ack_cwe", cache_wr_en, 1);
    chk("sh_ack_stall", stall, 0);
    chk("sh_ack_addr", mem_addr, 32'h0000_3002);
    chk("sh_ack_wdata", mem_wdata, 32'hABCD_0000);
    tick(); mem_ack = 1'b0; settle();
    chk("sh_wb_valid", wb_valid, 1);
    chk("sh_wb_en", wb_en, 0);
    chk("sh_wb_rd", wb_rd, 3);
    chk("sh_fwd_en", fwd_en, 0);
    chk("sh_cwe_after", cache_wr_en, 0);
    chk("sh_req_after", mem_req, 0);
    tick(); settle();
    chk("sh_wb_pulse", wb_valid, 0);

    // SB miss acked in the first request cycle: no cache update
    present(3'd0, 2'd1, 32'h0000_3001, 32'h1234_565A, 5'd4, 1'b0, 32'h0);
    settle(); chk("sb_stall_idle", stall, 1);
    tick(); idle_in(); mem_ack = 1'b1; settle();
    chk("sb_req", mem_req, 1);
    chk("sb_wdata", mem_wdata, 32'h3456_5A00);
    chk("sb_wstrb", mem_wstrb, 4'h2);
    chk("sb_cwe", cache_wr_en, 0);
    chk("sb_stall", stall, 0);
    tick(); mem_ack = 1'b0; settle();
    chk("sb_wb_valid", wb_valid, 1);
    chk("sb_req_after", mem_req, 0);
    tick();

    // Misaligned LW and SH
    present(3'd3, 2'd0, 32'h0000_4001, 32'h0, 5'd6, 1'b1, 32'hFFFF_FFFF);
    settle();
    chk("mlw_stall", stall, 0);
    chk("mlw_req_idle", mem_req, 0);
    tick(); idle_in(); settle();
    chk("mlw_misalign", misalign, 1);
    chk("mlw_wb_valid", wb_valid, 1);
    chk("mlw_wb_en", wb_en, 0);
    chk("mlw_wb_rd", wb_rd, 6);
    chk("mlw_fwd_en", fwd_en, 0);
    chk("mlw_req", mem_req, 0);
    tick(); settle();
    chk("mlw_misalign_pulse", misalign, 0);
    chk("mlw_wb_pulse", wb_valid, 0);
    present(3'd0, 2'd2, 32'h0000_3003, 32'h0000_1111, 5'd7, 1'b1, 32'h0);
    settle(); chk("msh_stall", stall, 0);
    tick(); idle_in(); settle();
    chk("msh_misalign", misalign, 1);
    chk("msh_req", mem_req, 0);
    tick();

    // Reset on the second refill beat aborts the miss
    present(3'd3, 2'd0, 32'h0000_2008, 32'h0, 5'd11, 1'b0, 32'h0);
    tick(); idle_in();
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111; settle();
    chk("abort_addr0", mem_addr, 32'h0000_2000);
    tick();
    mem_rdata = 32'h2222_2222; rst = 1'b1; settle();
    chk("abort_addr1", mem_addr, 32'h0000_2004);
    chk("abort_idx1", refill_idx, 1);
    tick(); rst = 1'b0; settle();
    chk("abort_req", mem_req, 0);
    chk("abort_refill_we", refill_we, 0);
    chk("abort_wb_valid", wb_valid, 0);
    chk("abort_stall", stall, 0);
    tick(); mem_ack = 1'b0; settle();
    chk("abort_wb_valid2", wb_valid, 0);
    chk("abort_req2", mem_req, 0);
    present(3'd3, 2'd0, 32'h0000_1000, 32'h0, 5'd12, 1'b1, 32'hDEAD_BEEF);
    settle(); chk("post_stall", stall, 0);
    tick(); idle_in(); settle();
    chk("post_wb_valid", wb_valid, 1);
    chk("post_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("post_wb_rd", wb_rd, 12);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
